// File: rtl/dac_wr_receiver.sv
// rtl/dac_wr_receiver.sv - receiver for an asynchronous CS/WR 8-bit DAC write bus
// Synchronises the strobes, measures WR-low width and accepts or rejects each write.
module dac_wr_receiver #(
  parameter logic [7:0] MinWrLow   = 8'd10,
  parameter int         SyncStages = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CS,
  input  logic        WR,
  input  logic [7:0]  DIN,
  input  logic        ClrErr,
  output logic [7:0]  DataOut,
  output logic        DataValid,
  output logic [7:0]  LastWidth,
  output logic [15:0] WrCount,
  output logic        ErrShort,
  output logic        ErrProto,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, SEL, WRL, DONE} state_t;

  logic [SyncStages-1:0]      cs_sync_q, cs_sync_d;
  logic [SyncStages-1:0]      wr_sync_q, wr_sync_d;
  logic [SyncStages-1:0]      fill_q, fill_d;
  logic [SyncStages-1:0][7:0] din_sync_q, din_sync_d;

  logic       cs_s, wr_s, fill_s;
  logic [7:0] din_s;

  state_t      state_q, state_d;
  logic        arm_q, arm_d;
  logic [7:0]  width_q, width_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic [7:0]  last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        es_q, es_d;
  logic        ep_q, ep_d;
  logic        new_es, new_ep;

  assign cs_s   = cs_sync_q[SyncStages-1];
  assign wr_s   = wr_sync_q[SyncStages-1];
  assign din_s  = din_sync_q[SyncStages-1];
  assign fill_s = fill_q[SyncStages-1];

  always_comb begin
    cs_sync_d  = {cs_sync_q[SyncStages-2:0], CS};
    wr_sync_d  = {wr_sync_q[SyncStages-2:0], WR};
    din_sync_d = {din_sync_q[SyncStages-2:0], DIN};
    fill_d     = {fill_q[SyncStages-2:0], 1'b1};
    // Arming needs a real CS-high sample, so a bus still low across reset is ignored.
    arm_d      = arm_q | (fill_s & cs_s);
    state_d    = state_q;
    width_d    = width_q;
    cap_d      = cap_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;
    new_es     = 1'b0;
    new_ep     = 1'b0;

    case (state_q)
      IDLE: begin
        if (arm_q && !cs_s) begin
          if (wr_s) begin
            state_d = SEL;
          end else begin
            state_d = WRL;
            width_d = 8'd1;
            new_ep  = 1'b1;
          end
        end
      end
      SEL: begin
        if (!wr_s) begin
          state_d = WRL;
          width_d = 8'd1;
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      WRL: begin
        if (cs_s) begin
          state_d = IDLE;
          new_ep  = 1'b1;
        end else if (!wr_s) begin
          width_d = (width_q == 8'hFF) ? width_q : width_q + 8'd1;
        end else begin
          state_d = DONE;
          cap_d   = din_s;
        end
      end
      DONE: begin
        last_d = width_q;
        if (width_q >= MinWrLow) begin
          data_d  = cap_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          new_es = 1'b1;
        end
        state_d = cs_s ? IDLE : SEL;
      end
      default: state_d = IDLE;
    endcase

    es_d = (es_q & ~ClrErr) | new_es;
    ep_d = (ep_q & ~ClrErr) | new_ep;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cs_sync_q  <= '1;
      wr_sync_q  <= '1;
      din_sync_q <= '0;
      fill_q     <= '0;
      arm_q      <= 1'b0;
      state_q    <= IDLE;
      width_q    <= 8'd0;
      cap_q      <= 8'd0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      last_q     <= 8'd0;
      cnt_q      <= 16'd0;
      es_q       <= 1'b0;
      ep_q       <= 1'b0;
    end else begin
      cs_sync_q  <= cs_sync_d;
      wr_sync_q  <= wr_sync_d;
      din_sync_q <= din_sync_d;
      fill_q     <= fill_d;
      arm_q      <= arm_d;
      state_q    <= state_d;
      width_q    <= width_d;
      cap_q      <= cap_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      es_q       <= es_d;
      ep_q       <= ep_d;
    end
  end

  assign DataOut   = data_q;
  assign DataValid = valid_q;
  assign LastWidth = last_q;
  assign WrCount   = cnt_q;
  assign ErrShort  = es_q;
  assign ErrProto  = ep_q;
  assign Busy      = (state_q == SEL) || (state_q == WRL);

endmodule

// File: tb/tb_dac_wr_receiver.sv
// tb/tb_dac_wr_receiver.sv - randomized bench for dac_wr_receiver with a transaction-level model
// Drivers schedule expected outcomes at the edge they must appear; one monitor compares every cycle.
module tb_dac_wr_receiver;
  localparam int         S   = 2;
  localparam logic [7:0] MIN = 8'd10;
  localparam int K_RST = 0, K_CLR = 1, K_DONE = 2, K_PERR = 3;

  logic        CLK = 1'b0, RST = 1'b0, CS = 1'b1, WR = 1'b1, ClrErr = 1'b0;
  logic [7:0]  DIN = 8'd0;
  logic [7:0]  DataOut, LastWidth;
  logic        DataValid, ErrShort, ErrProto, Busy;
  logic [15:0] WrCount;

  dac_wr_receiver #(.MinWrLow(MIN), .SyncStages(S)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .WR(WR), .DIN(DIN), .ClrErr(ClrErr),
    .DataOut(DataOut), .DataValid(DataValid), .LastWidth(LastWidth),
    .WrCount(WrCount), .ErrShort(ErrShort), .ErrProto(ErrProto), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  typedef struct {int e; int kind; int w; logic [7:0] d;} ev_t;
  ev_t evq[$];

  logic [7:0]  m_dout = 8'd0, m_lw = 8'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_es = 1'b0, m_ep = 1'b0;
  bit          mon_en = 1'b0;
  int checks = 0, errors = 0;
  int last_nq = 0, last_sample = 0;
  int vcount = 0, exp_vcount = 0, last_valid_edge = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic ev_t mk(int e, int kind, int w, logic [7:0] d);
    ev_t v;
    v.e = e; v.kind = kind; v.w = w; v.d = d;
    return v;
  endfunction

  // One bus cycle; the values set here are sampled by the DUT at edge last_sample.
  task automatic step_full(bit cs, bit wr, logic [7:0] d, bit rst_n, bit clr);
    @(negedge CLK);
    CS = cs; WR = wr; DIN = d; RST = rst_n; ClrErr = clr;
    last_sample = edge_cnt + 1;
    if (!(cs && wr) || !rst_n) last_nq = last_sample;
    if (!rst_n) evq.push_back(mk(last_sample, K_RST, 0, 8'd0));
    if (clr) evq.push_back(mk(last_sample, K_CLR, 0, 8'd0));
  endtask

  task automatic step(bit cs, bit wr, logic [7:0] d);
    step_full(cs, wr, d, 1'b1, 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b1, 1'b1, 8'($urandom));
  endtask

  task automatic clr_err();
    step_full(1'b1, 1'b1, 8'd0, 1'b1, 1'b1);
    idle(S + 3);
  endtask

  task automatic sel(int n, logic [7:0] d);
    repeat (n) step(1'b0, 1'b1, d);
  endtask

  // WR low for w samples then the rising sample k; the outcome lands at k+S+1.
  task automatic strobe(int w, logic [7:0] d, output int k);
    repeat (w) step(1'b0, 1'b0, d);
    step(1'b0, 1'b1, d);
    k = last_sample;
    evq.push_back(mk(k + S + 1, K_DONE, w, d));
  endtask

  task automatic abort(int mode, logic [7:0] d);
    if (mode == 1) begin
      step(1'b1, 1'b0, d);
      evq.push_back(mk(last_sample + S, K_PERR, 0, 8'd0));
      step(1'b1, 1'b1, d);
    end else begin
      step(1'b1, 1'b1, d);
      evq.push_back(mk(last_sample + S, K_PERR, 0, 8'd0));
    end
  endtask

  task automatic wr_before_cs(int r, int m);
    repeat (r) step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    evq.push_back(mk(last_sample + S, K_PERR, 0, 8'd0));
    repeat (m - 1) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);
  endtask

  function automatic int pick_w();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(1, MIN - 1));
      1, 2:    return int'($urandom_range(MIN, MIN + 4));
      default: return int'($urandom_range(MIN + 5, 40));
    endcase
  endfunction

  // Monitor: apply events due at this edge (reset, then clear, then new outcomes) and compare.
  initial begin
    forever begin
      bit   exp_v, had_rst;
      ev_t  keep[$];
      @(negedge CLK);
      exp_v = 1'b0; had_rst = 1'b0;
      for (int p = 0; p < 3; p++) begin
        foreach (evq[i]) begin
          if (evq[i].e != edge_cnt) continue;
          if (p == 0 && evq[i].kind == K_RST) begin
            had_rst = 1'b1;
            m_dout = 8'd0; m_cnt = 16'd0; m_lw = 8'd0; m_es = 1'b0; m_ep = 1'b0;
          end else if (p == 1 && evq[i].kind == K_CLR) begin
            m_es = 1'b0; m_ep = 1'b0;
          end else if (p == 2 && evq[i].kind == K_PERR) begin
            m_ep = 1'b1;
          end else if (p == 2 && evq[i].kind == K_DONE) begin
            m_lw = (evq[i].w > 255) ? 8'hFF : 8'(evq[i].w);
            if (evq[i].w >= int'(MIN)) begin
              m_dout = evq[i].d; m_cnt = m_cnt + 16'd1; exp_v = 1'b1;
            end else begin
              m_es = 1'b1;
            end
          end
        end
      end
      keep = {};
      foreach (evq[i])
        if (evq[i].e > edge_cnt && (!had_rst || evq[i].kind <= K_CLR)) keep.push_back(evq[i]);
      evq = keep;
      if (mon_en) begin
        chk("DataValid", 32'(DataValid), 32'(exp_v));
        chk("DataOut", 32'(DataOut), 32'(m_dout));
        chk("WrCount", 32'(WrCount), 32'(m_cnt));
        chk("LastWidth", 32'(LastWidth), 32'(m_lw));
        chk("ErrShort", 32'(ErrShort), 32'(m_es));
        chk("ErrProto", 32'(ErrProto), 32'(m_ep));
        if (edge_cnt - last_nq >= S + 3) chk("Busy_quiet", 32'(Busy), 32'd0);
        if (DataValid === 1'b1) begin vcount++; last_valid_edge = edge_cnt; end
        if (exp_v) exp_vcount++;
      end
    end
  end

  initial begin
    int k, w, n, mode, v0;
    logic [7:0] d;
    repeat (3) step_full(1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
    idle(S + 4);
    mon_en = 1'b1;
    chk("rst_DataOut", 32'(DataOut), 32'd0);
    chk("rst_DataValid", 32'(DataValid), 32'd0);
    chk("rst_LastWidth", 32'(LastWidth), 32'd0);
    chk("rst_WrCount", 32'(WrCount), 32'd0);
    chk("rst_Errs", {30'd0, ErrShort, ErrProto}, 32'd0);
    chk("rst_Busy", 32'(Busy), 32'd0);

    // Nominal 12-cycle write of 8'hFF
    sel(2, 8'hFF); strobe(12, 8'hFF, k); step(1'b0, 1'b1, 8'hFF); step(1'b1, 1'b1, 8'hFF);
    idle(S + 6);
    chk("nom_DataOut", 32'(DataOut), 32'hFF);
    chk("nom_LastWidth", 32'(LastWidth), 32'd12);
    chk("nom_WrCount", 32'(WrCount), 32'd1);
    chk("nom_Errs", {30'd0, ErrShort, ErrProto}, 32'd0);
    chk("nom_pulses", 32'(vcount), 32'd1);
    chk("nom_latency", 32'(last_valid_edge - k), 32'(S + 1));

    // Short 5-cycle strobe
    sel(2, 8'h3C); strobe(5, 8'h3C, k); step(1'b0, 1'b1, 8'h3C); step(1'b1, 1'b1, 8'h3C);
    idle(S + 6);
    chk("short_ErrShort", 32'(ErrShort), 32'd1);
    chk("short_DataOut", 32'(DataOut), 32'hFF);
    chk("short_LastWidth", 32'(LastWidth), 32'd5);
    chk("short_pulses", 32'(vcount), 32'd1);
    clr_err();
    chk("clr_ErrShort", 32'(ErrShort), 32'd0);

    // WR low while CS high, then CS falls
    wr_before_cs(2, 2); idle(S + 4);
    chk("wrfirst_ErrProto", 32'(ErrProto), 32'd1);
    clr_err();
    chk("clr_ErrProto", 32'(ErrProto), 32'd0);

    // CS rises while WR is low
    sel(2, 8'hAA); repeat (4) step(1'b0, 1'b0, 8'hAA);
    chk("wrl_Busy", 32'(Busy), 32'd1);
    abort(1, 8'hAA); idle(S + 4);
    chk("csabort_ErrProto", 32'(ErrProto), 32'd1);
    chk("csabort_DataOut", 32'(DataOut), 32'hFF);
    chk("csabort_WrCount", 32'(WrCount), 32'd1);
    clr_err();
    chk("clr_both", {30'd0, ErrShort, ErrProto}, 32'd0);

    // Three back-to-back strobes under one CS
    sel(2, 8'h01);
    for (int i = 1; i <= 3; i++) begin
      strobe(10, 8'(i), k); step(1'b0, 1'b1, 8'(i));
    end
    step(1'b1, 1'b1, 8'h03); idle(S + 6);
    chk("b2b_WrCount", 32'(WrCount), 32'd4);
    chk("b2b_DataOut", 32'(DataOut), 32'h03);
    chk("b2b_pulses", 32'(vcount), 32'd4);

    // Count wrap from 16'hFFFF
    @(negedge CLK); mon_en = 1'b0; force dut.cnt_q = 16'hFFFF; m_cnt = 16'hFFFF;
    @(negedge CLK); release dut.cnt_q;
    @(negedge CLK); mon_en = 1'b1;
    sel(2, 8'h5A); strobe(12, 8'h5A, k); step(1'b0, 1'b1, 8'h5A); step(1'b1, 1'b1, 8'h5A);
    idle(S + 6);
    chk("wrap_WrCount", 32'(WrCount), 32'd0);
    chk("wrap_DataOut", 32'(DataOut), 32'h5A);

    // 300-cycle strobe saturates the width
    sel(2, 8'h77); strobe(300, 8'h77, k); step(1'b0, 1'b1, 8'h77); step(1'b1, 1'b1, 8'h77);
    idle(S + 6);
    chk("sat_LastWidth", 32'(LastWidth), 32'd255);
    chk("sat_WrCount", 32'(WrCount), 32'd1);

    // Reset pulse in the middle of a write, bus still low afterwards
    v0 = vcount;
    sel(2, 8'h99); repeat (5) step(1'b0, 1'b0, 8'h99);
    step_full(1'b0, 1'b0, 8'h99, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 8'h99);
    step(1'b1, 1'b1, 8'h99); idle(S + 6);
    chk("rstmid_outputs", {LastWidth, DataOut, WrCount}, 32'd0);
    chk("rstmid_Errs", {30'd0, ErrShort, ErrProto}, 32'd0);
    chk("rstmid_pulses", 32'(vcount), 32'(v0));
    sel(2, 8'hC3); strobe(11, 8'hC3, k); step(1'b0, 1'b1, 8'hC3); step(1'b1, 1'b1, 8'hC3);
    idle(S + 6);
    chk("rstmid_next_WrCount", 32'(WrCount), 32'd1);
    chk("rstmid_next_DataOut", 32'(DataOut), 32'hC3);

    // Randomized traffic
    repeat (200) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          n = int'($urandom_range(1, 3));
          mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
          d = 8'($urandom);
          sel(int'($urandom_range(1, 3)), d);
          for (int i = 0; i < n; i++) begin
            w = pick_w(); d = 8'($urandom);
            if (i == n - 1 && mode != 0) begin
              repeat (w) step(1'b0, 1'b0, d);
              abort(mode, d);
            end else begin
              strobe(w, d, k);
              if (i < n - 1) begin
                repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, d);
              end else begin
                repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, d);
                step(1'b1, 1'b1, d);
              end
            end
          end
        end
        6: wr_before_cs(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
        7: begin sel(int'($urandom_range(1, 5)), 8'($urandom)); step(1'b1, 1'b1, 8'h00); end
        8: step_full(1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        default: idle(int'($urandom_range(1, 8)));
      endcase
      idle(int'($urandom_range(S + 3, S + 6)));
    end

    idle(S + 8);
    chk("events_drained", 32'(evq.size()), 32'd0);
    chk("pulse_total", 32'(vcount), 32'(exp_vcount));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
